// File: rtl/enigma_pkg.sv
// Shared types for the Enigma symbol collector: symbol encoding and controller states.
package enigma_pkg;

  typedef logic signed [6:0] symb_t;

  localparam symb_t IDLE_SYMB    = 7'sd0;
  localparam int    DEF_MAX_SYMB = 26;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } coll_state_t;

endpackage

// File: rtl/symb_fifo.sv
// Symbol FIFO with extra-MSB pointers.
// The head is shown combinationally and forced to IDLE_SYMB when the FIFO is empty.
module symb_fifo
  import enigma_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  wr_i,
  input  symb_t wr_data_i,
  input  logic  rd_i,
  output symb_t rd_data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  symb_t       mem [DEPTH];
  logic        wr_ok;
  logic        rd_ok;

  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty_o = (wr_ptr == rd_ptr);

  // A read on the same edge frees the slot, so a write into a full FIFO is still taken.
  assign wr_ok = wr_i && (!full_o || rd_i);
  assign rd_ok = rd_i && !empty_o;

  assign rd_data_o = empty_o ? IDLE_SYMB : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/enigma_collector.sv
// Collects a target number of legal letter symbols from a sparse cipher stream.
// The symbols are buffered in a FIFO and drained downstream.
module enigma_collector
  import enigma_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_SYMB   = DEF_MAX_SYMB
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] symb_numb_i,
  input  symb_t      symb_i,
  input  logic       rdy_i,
  output symb_t      symb_o,
  output logic       vld_o,
  output logic [7:0] cnt_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       ovf_o
);

  coll_state_t state;
  logic [7:0]  tgt_q;
  logic        fifo_full;
  logic        fifo_empty;
  logic        sym_legal;
  logic        sym_illegal;
  logic        wr_req;
  logic        rd_req;
  logic        wr_drop;
  logic [7:0]  cnt_inc;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign sym_legal   = (symb_i > IDLE_SYMB) && (int'(symb_i) <= MAX_SYMB);
  assign sym_illegal = (symb_i != IDLE_SYMB) && !sym_legal;
  assign wr_req      = (state == COLLECT) && sym_legal;
  assign rd_req      = vld_o && rdy_i;
  assign wr_drop     = wr_req && fifo_full && !rd_req;
  assign cnt_inc     = sat_inc8(cnt_o);
  assign vld_o       = !fifo_empty;

  symb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_i     (wr_req),
    .wr_data_i(symb_i),
    .rd_i     (rd_req),
    .rd_data_o(symb_o),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (state == IDLE && start_i) tgt_q <= symb_numb_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      cnt_o  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            cnt_o <= '0;
            err_o <= 1'b0;
            ovf_o <= 1'b0;
            if (symb_numb_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state  <= COLLECT;
              busy_o <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (sym_illegal) err_o <= 1'b1;
          if (wr_drop)     ovf_o <= 1'b1;
          // The target is compared against the post-increment count so the final symbol ends the run.
          if (wr_req) begin
            cnt_o <= cnt_inc;
            if (cnt_inc == tgt_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state  <= DONE;
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_collector.sv
// Bench for enigma_collector.
// It uses directed scenarios plus random traffic against a queue-based reference model.
module tb_enigma_collector;
  import enigma_pkg::*;

  localparam int DEPTH = 16;
  localparam int MAXS  = 26;

  logic       clk_i       = 1'b0;
  logic       rst_i       = 1'b0;
  logic       start_i     = 1'b0;
  logic [7:0] symb_numb_i = '0;
  symb_t      symb_i      = '0;
  logic       rdy_i       = 1'b0;
  symb_t      symb_o;
  logic       vld_o;
  logic [7:0] cnt_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic       ovf_o;

  int ntests = 0;
  int nfail  = 0;

  // reference model: 0 idle, 1 collect, 2 drain, 3 done
  int m_state;
  int m_cnt;
  int m_tgt;
  bit m_err;
  bit m_ovf;
  int q[$];

  int outs[$];
  int done_seen;

  enigma_collector #(
    .FIFO_DEPTH(DEPTH),
    .MAX_SYMB  (MAXS)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .symb_numb_i(symb_numb_i),
    .symb_i     (symb_i),
    .rdy_i      (rdy_i),
    .symb_o     (symb_o),
    .vld_o      (vld_o),
    .cnt_o      (cnt_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0;
    m_cnt   = 0;
    m_tgt   = 0;
    m_err   = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge(input bit st, input int n, input int s, input bit r);
    int  sz;
    bit  rd;
    bit  push;
    bit  legal;
    int  ns;
    sz    = q.size();
    rd    = (sz > 0) && r;
    push  = 1'b0;
    legal = (s >= 1) && (s <= MAXS);
    ns    = m_state;
    case (m_state)
      0: if (st) begin
        m_tgt = n;
        m_cnt = 0;
        m_err = 1'b0;
        m_ovf = 1'b0;
        ns    = (n == 0) ? 3 : 1;
      end
      1: begin
        if (legal) begin
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          if (sz < DEPTH || rd) push = 1'b1;
          else m_ovf = 1'b1;
          if (m_cnt == m_tgt) ns = 2;
        end else if (s != 0) begin
          m_err = 1'b1;
        end
      end
      2: if (sz == 0) ns = 3;
      default: ns = 0;
    endcase
    m_state = ns;
    if (rd) void'(q.pop_front());
    if (push) q.push_back(s);
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, "_vld"},  vld_o,  (q.size() > 0) ? 1 : 0);
    chk({pfx, "_symb"}, symb_o, (q.size() > 0) ? q[0] : 0);
    chk({pfx, "_cnt"},  cnt_o,  m_cnt);
    chk({pfx, "_busy"}, busy_o, (m_state == 1 || m_state == 2) ? 1 : 0);
    chk({pfx, "_done"}, done_o, (m_state == 3) ? 1 : 0);
    chk({pfx, "_err"},  err_o,  m_err);
    chk({pfx, "_ovf"},  ovf_o,  m_ovf);
  endtask

  task automatic step(input bit st, input int n, input int s, input bit r);
    @(negedge clk_i);
    start_i     = st;
    symb_numb_i = 8'(n);
    symb_i      = symb_t'(s);
    rdy_i       = r;
    #1;
    if (vld_o && rdy_i) outs.push_back(int'(symb_o));
    model_edge(st, n, s, r);
    @(posedge clk_i);
    #1;
    check_all("cyc");
    if (done_o) done_seen++;
  endtask

  function automatic int rand_symbol();
    int k;
    k = int'($urandom_range(0, 9));
    if (k < 5) return 0;
    if (k < 9) return int'($urandom_range(1, MAXS));
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(MAXS + 1, 63));
    return -int'($urandom_range(1, 64));
  endfunction

  initial begin
    int s1[13];
    int e1[5];
    s1 = '{3, 0, 0, 7, 0, 0, 26, 0, 0, 1, 0, 0, 12};
    e1 = '{3, 7, 26, 1, 12};

    model_reset();
    #2;
    check_all("rst");
    @(posedge clk_i);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    check_all("rel");

    // basic run with idle gaps
    outs.delete();
    done_seen = 0;
    step(1'b1, 5, 0, 1'b1);
    foreach (s1[i]) step(1'b0, 0, s1[i], 1'b1);
    repeat (8) step(1'b0, 0, 0, 1'b1);
    chk("s1_nout", outs.size(), 5);
    for (int i = 0; i < 5; i++) chk("s1_order", (i < outs.size()) ? outs[i] : -999, e1[i]);
    chk("s1_done", done_seen, 1);
    chk("s1_cnt", cnt_o, 5);
    chk("s1_err", err_o, 0);
    chk("s1_ovf", ovf_o, 0);

    // overflow with downstream stalled
    outs.delete();
    done_seen = 0;
    step(1'b1, 20, 0, 1'b0);
    repeat (20) step(1'b0, 0, int'($urandom_range(1, MAXS)), 1'b0);
    chk("s2_cnt", cnt_o, 20);
    chk("s2_ovf", ovf_o, 1);
    chk("s2_busy", busy_o, 1);
    repeat (5) step(1'b0, 0, 0, 1'b0);
    chk("s2_hold", busy_o, 1);
    repeat (20) step(1'b0, 0, 0, 1'b1);
    chk("s2_nout", outs.size(), 16);
    chk("s2_done", done_seen, 1);

    // out-of-range symbols
    outs.delete();
    step(1'b1, 1, 0, 1'b1);
    step(1'b0, 0, 27, 1'b1);
    step(1'b0, 0, -3, 1'b1);
    step(1'b0, 0, 5, 1'b1);
    repeat (4) step(1'b0, 0, 0, 1'b1);
    chk("s3_err", err_o, 1);
    chk("s3_cnt", cnt_o, 1);
    chk("s3_nout", outs.size(), 1);
    chk("s3_val", (outs.size() > 0) ? outs[0] : -999, 5);

    // zero-length run
    outs.delete();
    done_seen = 0;
    step(1'b1, 0, 0, 1'b1);
    chk("s4_done_hi", done_o, 1);
    step(1'b0, 0, 0, 1'b1);
    chk("s4_done_lo", done_o, 0);
    chk("s4_nout", outs.size(), 0);
    chk("s4_pulses", done_seen, 1);

    // full FIFO with simultaneous read and write
    step(1'b1, 20, 0, 1'b0);
    repeat (16) step(1'b0, 0, int'($urandom_range(1, MAXS)), 1'b0);
    chk("s5_cnt16", cnt_o, 16);
    chk("s5_ovf_pre", ovf_o, 0);
    step(1'b0, 0, 9, 1'b1);
    chk("s5_ovf_post", ovf_o, 0);
    chk("s5_cnt17", cnt_o, 17);
    repeat (3) step(1'b0, 0, int'($urandom_range(1, MAXS)), 1'b1);
    repeat (20) step(1'b0, 0, 0, 1'b1);
    chk("s5_ovf_end", ovf_o, 0);

    // asynchronous reset mid-collect
    step(1'b1, 10, 0, 1'b0);
    repeat (4) step(1'b0, 0, int'($urandom_range(1, MAXS)), 1'b0);
    chk("s6_cnt4", cnt_o, 4);
    chk("s6_vld4", vld_o, 1);
    #2 rst_i = 1'b0;
    #1;
    model_reset();
    chk("s6_async_vld", vld_o, 0);
    chk("s6_async_cnt", cnt_o, 0);
    chk("s6_async_busy", busy_o, 0);
    chk("s6_async_symb", symb_o, 0);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    check_all("s6_rel");
    repeat (3) step(1'b0, 0, 5, 1'b1);
    chk("s6_idle_cnt", cnt_o, 0);
    outs.delete();
    done_seen = 0;
    step(1'b1, 3, 0, 1'b1);
    step(1'b0, 0, 4, 1'b1);
    step(1'b0, 0, 8, 1'b1);
    step(1'b0, 0, 15, 1'b1);
    repeat (6) step(1'b0, 0, 0, 1'b1);
    chk("s6_nout", outs.size(), 3);
    chk("s6_done", done_seen, 1);

    // random traffic
    repeat (1500) begin
      bit st;
      bit r;
      st = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 3) != 0);
      step(st, int'($urandom_range(0, 30)), rand_symbol(), r);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
